// File: rtl/ape_result_drain.sv
// Result drain: buffers processed data words from the core in a small FIFO and appends
// the message tag as a final word once the message's data has fully left.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// STREAM   | accepting data words; FIFO head presented downstream
// TAG_PEND | last word accepted, input stalled, draining buffered data
// TAG_OUT  | FIFO empty, presenting the tag word until the host takes it
module ape_result_drain #(
   parameter int DW    = 34,
   parameter int TW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk_1,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   input  logic [TW-1:0] in_tag,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_is_tag
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      ST_STREAM   = 2'd0,
      ST_TAG_PEND = 2'd1,
      ST_TAG_OUT  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [DW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [TW-1:0]   r_tag;

   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_tag_cap;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // Output side depends only on registered state, so in_ready/out_* never
   // combinationally follow the handshake inputs.
   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_is_tag = 1'b0;
      out_data   = '0;
      case (r_state)
         ST_STREAM: begin
            in_ready  = ~w_full;
            out_valid = ~w_empty;
            out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
         end
         ST_TAG_PEND: begin
            out_valid = ~w_empty;
            out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
         end
         ST_TAG_OUT: begin
            out_valid  = 1'b1;
            out_is_tag = 1'b1;
            out_data   = DW'(r_tag);
         end
         default: begin
            in_ready   = 1'b0;
            out_valid  = 1'b0;
         end
      endcase
   end

   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready & ~out_is_tag;
   assign w_tag_cap = (r_state == ST_STREAM) & w_push & in_last;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_STREAM: begin
            if (w_tag_cap) w_state_nxt = ST_TAG_PEND;
         end
         ST_TAG_PEND: begin
            if (w_empty) w_state_nxt = ST_TAG_OUT;
         end
         ST_TAG_OUT: begin
            if (out_ready) w_state_nxt = ST_STREAM;
         end
         default: w_state_nxt = ST_STREAM;
      endcase
   end

   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_STREAM;
         r_tag   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_tag_cap) r_tag <= in_tag;
      end
   end

   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

endmodule

// File: tb/tb_ape_result_drain.sv
// Bench for ape_result_drain: a per-cycle vector table for message framing plus
// hand-written sequences for reset, backpressure, pointer wrap and tag ordering.
module tb_ape_result_drain;

   logic        clk_1;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [33:0] in_data;
   logic        in_last;
   logic [15:0] in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [33:0] out_data;
   logic        out_is_tag;

   int n_chk = 0;
   int n_err = 0;

   typedef struct packed {
      logic        iv;
      logic [33:0] id;
      logic        il;
      logic [15:0] it;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic        e_tag;
      logic [33:0] e_data;
   } vec_t;

   typedef struct packed {
      logic [33:0] d;
      logic        l;
      logic [15:0] t;
   } src_t;

   vec_t        vecs [16];
   src_t        src_q [$];
   logic [34:0] exp_q [$];

   ape_result_drain #(.DW(34), .TW(16), .DEPTH(4)) dut (
      .clk_1      (clk_1),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_is_tag (out_is_tag)
   );

   initial clk_1 = 1'b0;
   always #5 clk_1 = ~clk_1;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample handshakes, score outputs, record accepted words, advance.
   task automatic tick(output bit acc, output bit th);
      logic [34:0] w;
      #1;
      acc = in_valid && in_ready;
      th  = out_valid && out_ready && out_is_tag;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL out_unexpected: got %0h expected nothing", {out_is_tag, out_data});
         end else begin
            w = exp_q.pop_front();
            chk("out_word", {29'h0, out_is_tag, out_data}, {29'h0, w});
         end
      end
      if (acc) begin
         exp_q.push_back({1'b0, in_data});
         if (in_last) exp_q.push_back({1'b1, 18'h0, in_tag});
      end
      @(posedge clk_1);
      #1;
   endtask

   // mode 0: out_ready held high; mode 1: out_ready toggles 1,0,1,0...
   task automatic run(input int mode, input int budget);
      int n;
      bit acc;
      bit th;
      n = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         if (src_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = src_q[0].d;
            in_last  = src_q[0].l;
            in_tag   = src_q[0].t;
         end else begin
            in_valid = 1'b0;
            in_data  = '0;
            in_last  = 1'b0;
            in_tag   = '0;
         end
         out_ready = (mode == 0) ? 1'b1 : ((n % 2) == 0);
         tick(acc, th);
         if (acc) void'(src_q.pop_front());
         n++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (src_q.size() > 0 || exp_q.size() > 0) begin
         n_chk++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", src_q.size() + exp_q.size());
         src_q.delete();
         exp_q.delete();
      end
   endtask

   task automatic push_word(input logic [33:0] d, input logic l, input logic [15:0] t,
                            input logic ordy, input logic exp_acc, input string name);
      bit acc;
      bit th;
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = l;
      in_tag    = t;
      out_ready = ordy;
      tick(acc, th);
      chk(name, 64'(acc), 64'(exp_acc));
   endtask

   task automatic idle_tick();
      bit acc;
      bit th;
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick(acc, th);
   endtask

   initial begin
      bit acc;
      bit th;
      bit tag_done;
      int n_bad;

      //         iv  id            il  it        ordy ir  ov  tag  data
      vecs[0]  = '{1'b1, 34'h1,         1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 34'h0};
      vecs[1]  = '{1'b1, 34'h2,         1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 1'b0, 34'h1};
      vecs[2]  = '{1'b1, 34'h3,         1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 34'h2};
      vecs[3]  = '{1'b0, 34'h0,         1'b0, 16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 34'h3};
      vecs[4]  = '{1'b0, 34'h0,         1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 34'h0};
      vecs[5]  = '{1'b0, 34'h0,         1'b0, 16'h0,    1'b1, 1'b0, 1'b1, 1'b1, 34'h0BEEF};
      vecs[6]  = '{1'b0, 34'h0,         1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 34'h0};
      vecs[7]  = '{1'b1, 34'h2AAAA5555, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 34'h0};
      vecs[8]  = '{1'b0, 34'h0,         1'b0, 16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 34'h2AAAA5555};
      vecs[9]  = '{1'b0, 34'h0,         1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 34'h0};
      vecs[10] = '{1'b0, 34'h0,         1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 1'b1, 34'h01234};
      vecs[11] = '{1'b1, 34'h7,         1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 1'b1, 34'h01234};
      vecs[12] = '{1'b1, 34'h7,         1'b0, 16'h0,    1'b1, 1'b0, 1'b1, 1'b1, 34'h01234};
      vecs[13] = '{1'b1, 34'h7,         1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 34'h0};
      vecs[14] = '{1'b0, 34'h0,         1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 1'b0, 34'h7};
      vecs[15] = '{1'b0, 34'h0,         1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 34'h0};

      // T1: reset held with random inputs
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      in_tag    = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_1);
         #1;
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 34'({$urandom(), $urandom()});
         in_last   = 1'($urandom_range(0, 1));
         in_tag    = 16'($urandom());
         out_ready = 1'($urandom_range(0, 1));
         #1;
         chk("reset_hold", {27'h0, in_ready, out_valid, out_is_tag, out_data},
             {27'h0, 1'b1, 1'b0, 1'b0, 34'h0});
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(posedge clk_1);
      #1;
      rst_n = 1'b1;

      // T2 + single-word message + tag hold: per-cycle vectors
      for (int i = 0; i < 16; i++) begin
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].id;
         in_last   = vecs[i].il;
         in_tag    = vecs[i].it;
         out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("vec%0d", i), {27'h0, in_ready, out_valid, out_is_tag, out_data},
             {27'h0, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_tag, vecs[i].e_data});
         @(posedge clk_1);
         #1;
      end

      // T1: asynchronous reset mid-cycle clears outputs before the next edge
      push_word(34'h5, 1'b0, 16'h0, 1'b0, 1'b1, "async_pre_accept");
      in_valid = 1'b0;
      chk("async_pre_valid", {27'h0, in_ready, out_valid, out_is_tag, out_data},
          {27'h0, 1'b1, 1'b1, 1'b0, 34'h5});
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_clear", {27'h0, in_ready, out_valid, out_is_tag, out_data},
          {27'h0, 1'b1, 1'b0, 1'b0, 34'h0});
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      @(posedge clk_1);
      #1;

      // T3: backpressure, full FIFO holds off the 5th word
      for (int i = 1; i <= 4; i++)
         push_word(34'(100 + i), 1'b0, 16'h0, 1'b0, 1'b1, "t3_accept");
      for (int i = 0; i < 2; i++)
         push_word(34'd105, 1'b0, 16'h0, 1'b0, 1'b0, "t3_full_stall");
      chk("t3_head_hold", {29'h0, out_valid, out_is_tag, out_data}, {29'h0, 1'b1, 1'b0, 34'd101});
      src_q.push_back('{34'd105, 1'b0, 16'h0});
      src_q.push_back('{34'd106, 1'b0, 16'h0});
      run(0, 50);

      // T4: push and pop in the same cycle at count 2, then wrap with toggling out_ready
      push_word(34'd201, 1'b0, 16'h0, 1'b0, 1'b1, "t4_fill");
      push_word(34'd202, 1'b0, 16'h0, 1'b0, 1'b1, "t4_fill");
      push_word(34'd203, 1'b0, 16'h0, 1'b1, 1'b1, "t4_push_pop");
      push_word(34'd204, 1'b0, 16'h0, 1'b0, 1'b1, "t4_refill");
      push_word(34'd205, 1'b0, 16'h0, 1'b0, 1'b1, "t4_refill");
      push_word(34'd206, 1'b0, 16'h0, 1'b0, 1'b0, "t4_full_at_4");
      run(0, 50);
      for (int i = 1; i <= 10; i++)
         src_q.push_back('{34'(300 + i), (i == 10), 16'h0A0A});
      run(1, 100);

      // T5: next message offered right behind the last word
      push_word(34'd401, 1'b0, 16'h0, 1'b0, 1'b1, "t5_fill");
      push_word(34'd402, 1'b0, 16'h0, 1'b0, 1'b1, "t5_fill");
      push_word(34'd403, 1'b1, 16'hCAFE, 1'b0, 1'b1, "t5_last");
      in_valid  = 1'b1;
      in_data   = 34'd501;
      in_last   = 1'b0;
      in_tag    = 16'h0;
      out_ready = 1'b1;
      tag_done  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick(acc, th);
         chk("t5_stall", 64'(acc), 64'(0));
         if (th) begin
            tag_done = 1'b1;
            break;
         end
      end
      chk("t5_tag_seen", 64'(tag_done), 64'(1));
      tick(acc, th);
      chk("t5_next_accept", 64'(acc), 64'(1));
      in_valid = 1'b0;
      run(0, 30);

      // T6: reset while draining a finished message; its tag must never appear
      push_word(34'd601, 1'b0, 16'h0, 1'b0, 1'b1, "t6_fill");
      push_word(34'd602, 1'b0, 16'h0, 1'b0, 1'b1, "t6_fill");
      push_word(34'd603, 1'b1, 16'hDEAD, 1'b0, 1'b1, "t6_last");
      idle_tick();
      idle_tick();
      #2;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      exp_q.delete();
      @(posedge clk_1);
      #1;
      chk("t6_after_rst", {27'h0, in_ready, out_valid, out_is_tag, out_data},
          {27'h0, 1'b1, 1'b0, 1'b0, 34'h0});
      out_ready = 1'b1;
      n_bad = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (out_valid) n_bad++;
         @(posedge clk_1);
         #1;
      end
      chk("t6_no_stale_out", 64'(n_bad), 64'(0));
      src_q.push_back('{34'd701, 1'b1, 16'h0777});
      run(0, 30);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
